// File: rtl/conv_ser_pkg.sv
// Shared types and helpers for the conv result serializer.
// CONV_SER_CRC_EN adds the CRC state to the FSM encoding.
package conv_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
`ifdef CONV_SER_CRC_EN
        ,
        ST_CRC  = 2'd2
`endif
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic int calc_bpf(input int n_out, input int out_w);
        return (n_out * out_w) / 8;
    endfunction

    // One whole byte of MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/conv_frame_fifo.sv
// Frame FIFO between the convolution core and the byte serializer.
// DEPTH must be a power of two so the pointers wrap naturally.
module conv_frame_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/conv_result_serializer.sv
// Buffers convolution result frames and streams them MSB-word/MSB-byte first.
// Define CONV_SER_CRC_EN to append a CRC-8 byte to every frame.
module conv_result_serializer
    import conv_ser_pkg::*;
#(
    parameter int N_OUT      = 4,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_spi,
    input  logic                          rst,
    input  logic [N_OUT*OUT_W-1:0]        conv_out,
    input  logic                          conv_valid,
    output logic                          conv_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic [15:0]                   frames_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int FW  = N_OUT * OUT_W;
    localparam int BPF = calc_bpf(N_OUT, OUT_W);
    localparam int CW  = $clog2(BPF + 1);
`ifdef CONV_SER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam bit LAST_ON_LOAD = !CRC_EN && (BPF == 1);

    state_t          state;
    logic [FW-1:0]   sr;
    logic [FW-1:0]   head;
    logic [CW-1:0]   byte_cnt;
    logic            full;
    logic            empty;
    logic            hs;
    logic            last_data;
    logic            frame_done;
    logic            pop;
`ifdef CONV_SER_CRC_EN
    logic [7:0]      crc;
    logic [7:0]      crc_next;
`endif

    conv_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_spi),
        .rst   (rst),
        .push  (conv_valid),
        .wdata (conv_out),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_level)
    );

    assign conv_ready = !full;

    always_comb begin
        hs        = tx_valid && tx_ready;
        last_data = (state == ST_SEND) && hs && (byte_cnt == CW'(BPF - 1));
`ifdef CONV_SER_CRC_EN
        crc_next   = crc8_byte(crc, tx_data);
        frame_done = (state == ST_CRC) && hs;
`else
        frame_done = last_data;
`endif
        // Popping on the closing handshake keeps frames back-to-back.
        pop = !empty && ((state == ST_IDLE) || frame_done);
    end

    always_ff @(posedge clk_spi or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sr          <= '0;
            byte_cnt    <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            frames_sent <= '0;
`ifdef CONV_SER_CRC_EN
            crc         <= '0;
`endif
        end else begin
            if (frame_done) frames_sent <= frames_sent + 16'd1;

            if (pop) begin
                state    <= ST_SEND;
                sr       <= head << 8;
                tx_data  <= head[FW-1 -: 8];
                tx_valid <= 1'b1;
                tx_last  <= LAST_ON_LOAD;
                byte_cnt <= '0;
`ifdef CONV_SER_CRC_EN
                crc      <= '0;
`endif
            end else if (frame_done) begin
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end else if ((state == ST_SEND) && hs) begin
                byte_cnt <= byte_cnt + 1'b1;
`ifdef CONV_SER_CRC_EN
                crc      <= crc_next;
`endif
                if (last_data) begin
`ifdef CONV_SER_CRC_EN
                    state   <= ST_CRC;
                    tx_data <= crc_next;
                    tx_last <= 1'b1;
`endif
                end else begin
                    tx_data <= sr[FW-1 -: 8];
                    sr      <= sr << 8;
                    tx_last <= !CRC_EN && (byte_cnt == CW'(BPF - 2));
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed bench for conv_result_serializer; CRC checks run when CONV_SER_CRC_EN is defined.
module tb_conv_result_serializer;
    localparam int N_OUT = 4;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;
    localparam int FW    = N_OUT * OUT_W;
    localparam int WB    = OUT_W / 8;
    localparam int BPF   = N_OUT * WB;
`ifdef CONV_SER_CRC_EN
    localparam int FB = BPF + 1;
`else
    localparam int FB = BPF;
`endif

    logic          clk_spi = 1'b0;
    logic          rst;
    logic [FW-1:0] conv_out;
    logic          conv_valid;
    logic          conv_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;
    logic [15:0]   frames_sent;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_checks = 0;
    int n_err    = 0;
    int proto_err = 0;
    int cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;

    logic [7:0] got_data[$];
    logic       got_last[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    conv_result_serializer #(.N_OUT(N_OUT), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_spi     (clk_spi),
        .rst         (rst),
        .conv_out    (conv_out),
        .conv_valid  (conv_valid),
        .conv_ready  (conv_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .frames_sent (frames_sent),
        .fifo_level  (fifo_level)
    );

    always #5 clk_spi = ~clk_spi;

    always @(posedge clk_spi) cyc <= cyc + 1;

    // Handshakes and stall stability are observed mid-cycle.
    always @(negedge clk_spi) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last))
                proto_err <= proto_err + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
            prev_last  <= tx_last;
            if (tx_valid && tx_ready) begin
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [7:0] fbyte(input logic [FW-1:0] f, input int j);
        int w;
        int b;
        w = N_OUT - 1 - j / WB;
        b = j % WB;
        return f[w*OUT_W + OUT_W - 1 - 8*b -: 8];
    endfunction

    function automatic logic [7:0] model_crc(input logic [FW-1:0] f);
        logic [7:0] c;
        logic [7:0] d;
        logic       fb;
        c = 8'h00;
        for (int j = 0; j < BPF; j++) begin
            d = fbyte(f, j);
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ d[k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic expect_frame(input logic [FW-1:0] f);
        for (int j = 0; j < BPF; j++) begin
            exp_data.push_back(fbyte(f, j));
            exp_last.push_back(j == FB - 1);
        end
        if (FB > BPF) begin
            exp_data.push_back(model_crc(f));
            exp_last.push_back(1'b1);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_frame(input logic [FW-1:0] f, input bit rec);
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        conv_out   = f;
        conv_valid = 1'b1;
        while (!ok && k < 200) begin
            @(negedge clk_spi);
            ok = conv_ready;
            @(posedge clk_spi);
            #1;
            k++;
        end
        conv_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
        if (rec) expect_frame(f);
    endtask

    task automatic wait_bytes(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (got_data.size() < n && k < limit) begin
            @(posedge clk_spi);
            #1;
            k++;
        end
        check(tag, got_data.size(), n);
    endtask

    task automatic cmp_stream(input string tag);
        int mm;
        mm = 0;
        check({tag, "_len"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++)
            if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
                mm++;
        check({tag, "_bytes"}, mm, 0);
    endtask

    initial begin
        logic [7:0]    bo_exp [8];
        logic [31:0]   lv;
        logic [FW-1:0] f;
        int            k;

        bo_exp = '{8'h00, 8'h12, 8'h00, 8'h34, 8'h00, 8'h56, 8'h00, 8'h78};
        rst = 1'b1; conv_valid = 1'b0; conv_out = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk_spi);
        #1;
        check("rst_conv_ready", 32'(conv_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_last", 32'(tx_last), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        @(posedge clk_spi);
        #1;

        // Byte order and first-byte latency
        clear_all();
        tx_ready   = 1'b1;
        conv_out   = 64'h0012_0034_0056_0078;
        conv_valid = 1'b1;
        expect_frame(conv_out);
        @(posedge clk_spi);
        #1;
        conv_valid = 1'b0;
        check("lat_e0_tx_valid", 32'(tx_valid), 32'd0);
        check("lat_e0_level", 32'(fifo_level), 32'd1);
        @(posedge clk_spi);
        #1;
        check("lat_e1_tx_valid", 32'(tx_valid), 32'd1);
        check("lat_e1_tx_data", 32'(tx_data), 32'h00);
        check("lat_e1_level", 32'(fifo_level), 32'd0);
        wait_bytes(FB, 50, "bo_count");
        for (int i = 0; i < 8; i++)
            check($sformatf("bo_byte%0d", i), 32'(got_data[i]), 32'(bo_exp[i]));
        lv = '0;
        for (int i = 0; i < FB; i++) lv[i] = got_last[i];
        check("bo_last_vec", lv, 32'(1) << (FB - 1));
        @(posedge clk_spi);
        #1;
        check("bo_frames_sent", 32'(frames_sent), 32'd1);
        check("bo_idle", 32'(tx_valid), 32'd0);

        // Backpressure: one frame in the shifter, four in the FIFO
        clear_all();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f = '0;
            for (int w = 0; w < N_OUT; w++)
                f[w*OUT_W +: OUT_W] = {8'(8'hA0 + i), 8'(8'hC0 + w)};
            push_frame(f, 1'b1);
        end
        check("bp_conv_ready", 32'(conv_ready), 32'd0);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_tx_data", 32'(tx_data), 32'hA0);
        conv_out   = {FW{1'b1}};
        conv_valid = 1'b1;
        repeat (3) @(posedge clk_spi);
        #1;
        conv_valid = 1'b0;
        check("bp_full_refuse", 32'(fifo_level), 32'd4);
        tx_ready = 1'b1;
        wait_bytes(5 * FB, 200, "bp_count");
        cmp_stream("bp");
        check("bp_no_bubble", got_cyc[5*FB-1] - got_cyc[0], 5 * FB - 1);
        @(posedge clk_spi);
        #1;
        check("bp_frames_sent", 32'(frames_sent), 32'd6);

        // Random tx_ready stalls over 100 frames
        clear_all();
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    f = {$urandom, $urandom};
                    push_frame(f, 1'b1);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_spi);
                        #1;
                    end
                end
            end
            begin
                k = 0;
                while (got_data.size() < 100 * FB && k < 8000) begin
                    @(posedge clk_spi);
                    #1;
                    tx_ready = ($urandom_range(0, 3) != 0);
                    k++;
                end
            end
        join
        tx_ready = 1'b1;
        wait_bytes(100 * FB, 100, "rnd_count");
        cmp_stream("rnd");
        @(posedge clk_spi);
        #1;
        check("rnd_frames_sent", 32'(frames_sent), 32'd106);

`ifdef CONV_SER_CRC_EN
        clear_all();
        push_frame('0, 1'b0);
        push_frame(64'h0000_0000_0000_0001, 1'b0);
        wait_bytes(2 * FB, 100, "crc_count");
        check("crc_zero", 32'(got_data[8]), 32'h00);
        check("crc_one", 32'(got_data[17]), 32'h07);
        check("crc_last_on_crc", 32'(got_last[17]), 32'd1);
        check("crc_last_not_data", 32'(got_last[16]), 32'd0);
`endif

        // frames_sent wrap
        @(posedge clk_spi);
        #1;
        force dut.frames_sent = 16'hFFFF;
        #1;
        release dut.frames_sent;
        #1;
        check("wrap_preload", 32'(frames_sent), 32'hFFFF);
        clear_all();
        push_frame(64'h1111_2222_3333_4444, 1'b0);
        wait_bytes(FB, 50, "wrap_count0");
        check("wrap_zero", 32'(frames_sent), 32'h0000);
        clear_all();
        push_frame(64'h5555_6666_7777_8888, 1'b0);
        wait_bytes(FB, 50, "wrap_count1");
        check("wrap_one", 32'(frames_sent), 32'h0001);

        // Reset mid-frame
        tx_ready = 1'b0;
        push_frame(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        push_frame(64'hCAFE_BABE_1234_5678, 1'b0);
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        check("pre_rst_level", 32'(fifo_level), 32'd1);
        @(posedge clk_spi);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_conv_ready", 32'(conv_ready), 32'd1);
        check("mid_rst_frames_sent", 32'(frames_sent), 32'd0);
        @(posedge clk_spi);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk_spi);
        #1;
        check("post_rst_idle", 32'(tx_valid), 32'd0);

        check("proto_stable", proto_err, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_result_serializer.md
# conv_result_serializer

Downstream of the 2x2 convolution core. Captures each parallel result frame (N_OUT unsigned OUT_W-bit sums), buffers up to FIFO_DEPTH frames, and streams them out as bytes over a valid/ready byte interface toward the SPI transmit path. Backpressure propagates upstream through `conv_ready`, so no frame is ever dropped.

## Interface
- `N_OUT`, 4, result words per frame.
- `OUT_W`, 16, bits per result word; must be a multiple of 8.
- `FIFO_DEPTH`, 4, frames buffered; must be a power of 2, ≥ 2.
- `clk_spi` input 1: the single clock for the block.
- `rst` input 1: asynchronous, active-high reset.
- `conv_out` input N_OUT*OUT_W: result frame. Word k is `conv_out[k*OUT_W +: OUT_W]`.
- `conv_valid` input 1: `conv_out` holds a valid frame.
- `conv_ready` output 1: the block can accept a frame.
- `tx_data` output 8: output byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: the sink accepts the byte.
- `tx_last` output 1: the current byte is the last byte of its frame.
- `frames_sent` output 16: count of completed frames; wraps at 2^16.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of frames currently buffered.

## Operation
- Push:
  - A frame is accepted on any edge where `conv_valid && conv_ready`.
  - `conv_ready = !full`, purely from the registered FIFO count.
  - Push is refused while the FIFO is full, even if a pop occurs in the same cycle.
- Byte order:
  - Words go out from word N_OUT-1 down to word 0.
  - Each word is sent MSB byte first.
  - BPF = N_OUT*OUT_W/8 data bytes per frame (8 at defaults).
- FSM states: IDLE, SEND, CRC (CRC exists only with the macro).
  - IDLE: if the FIFO is non-empty, pop the head frame into the shift register, clear the byte counter, go to SEND.
  - SEND: `tx_valid = 1` and `tx_data` = top byte of the shift register. On each handshake, shift left 8 and increment the byte counter.
  - SEND, last data byte handshake without CRC: increment `frames_sent`. If the FIFO is non-empty, pop and reload, staying in SEND with no bubble; otherwise go to IDLE.
  - SEND, last data byte handshake with CRC: go to CRC.
  - CRC: present the CRC byte with `tx_last = 1`. On its handshake, increment `frames_sent`, then reload-or-IDLE exactly as in SEND.
- `tx_last` is high only on the final byte of a frame.
- AXI-stream rules:
  - `tx_data` and `tx_last` stay stable while `tx_valid && !tx_ready`.
  - `tx_valid`, once high, never drops before its handshake.
- `fifo_level` tracks push and pop; a simultaneous push and pop leaves it unchanged.
- `frames_sent` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: `conv_ready = 1`, `tx_valid = 0`, `tx_data = 0`, `tx_last = 0`, `frames_sent = 0`, `fifo_level = 0`, state IDLE.
- Reset in the middle of a frame aborts the frame, discards all buffered frames and de-asserts `tx_valid` immediately (asynchronous).
- Latency: frame accepted at edge E0 → popped at E1 → `tx_valid` high in the cycle after E1.
- With `tx_ready` held high, throughput is 1 byte per cycle, and frames run back-to-back with no idle cycle.
- All outputs are registered except `conv_ready`, which is a compare on the registered count.

## Configuration
- `CONV_SER_CRC_EN` defined:
  - A CRC-8 byte follows each frame; frames are BPF+1 bytes.
  - Polynomial 0x07, init 0x00, non-reflected, no final XOR.
  - Covers the BPF data bytes in transmitted order, updated on each data handshake, cleared on frame load.
- Not defined: the CRC state and CRC logic are absent; frames are exactly BPF bytes.

## Structure
- Shared package `conv_ser_pkg` holds:
  - FSM state encoding (IDLE/SEND/CRC).
  - `CRC8_POLY = 8'h07`.
  - Function computing BPF from N_OUT and OUT_W.
- Sub-module `conv_frame_fifo`:
  - Synchronous FIFO, width N_OUT*OUT_W, depth FIFO_DEPTH.
  - Outputs full, empty and count.
  - Same clock and asynchronous active-high reset.
- The top level contains the FSM, shift register, byte counter, CRC and `frames_sent`.

## Test plan
- Reset: assert `rst` mid-frame → `tx_valid` drops asynchronously, `fifo_level = 0`, `conv_ready = 1`, `frames_sent = 0`.
- Byte order: push `conv_out = {16'h0012,16'h0034,16'h0056,16'h0078}` with `tx_ready = 1`, CRC off → bytes 00 12 00 34 00 56 00 78.
  - `tx_last` is high on 0x78 only.
  - First `tx_valid` is 2 cycles after the push edge.
  - `frames_sent = 1` afterwards.
- Backpressure and full:
  - Hold `tx_ready = 0` and push 5 frames → the first is loaded into the shift register, the next 4 fill the FIFO.
  - `conv_ready` drops with `fifo_level = 4`.
  - `tx_data` is held stable throughout.
  - Release `tx_ready` → all 5 frames emerge in order with no bubbles (40 consecutive bytes).
- Random `tx_ready` stall pattern over 100 frames → output byte stream matches the reference model; `tx_valid` never drops without a handshake.
- CRC enabled:
  - An all-zero frame → 9th byte 0x00.
  - A frame with only word 0 = 16'h0001 → CRC byte 0x07, and `tx_last` is on the CRC byte.
- Wrap: preload `frames_sent` via 65 536 frames (or a force) → 0xFFFF increments to 0x0000.
